assign_chain: RTL and testbench
===============================

# assign_chain

Parametrised accumulate-chain pipeline that produces a first-stage sum `a = b + d` and a final sum `c = b + DEPTH*d` for each accepted operand pair. The block generalises the fixed 4-bit two-register circuits to configurable width and depth, and adds valid/ready flow control. A runtime mode selects either a DEPTH-stage shift pipeline or a collapsed single-register evaluation. It sits between operand producers and result consumers in the arithmetic datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- DEPTH, 2, number of chained add stages (≥2); also the pipelined-mode latency
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept this cycle
- b  input  WIDTH  base operand
- d  input  WIDTH  increment operand
- collapse  input  1  mode request: 1 = collapsed, 0 = pipelined
- out_valid  output  1  result pair available
- out_ready  input  1  consumer takes the result
- a  output  WIDTH  b + d of the presented transaction
- c  output  WIDTH  b + DEPTH*d of the presented transaction
- busy  output  1  at least one stage holds a valid transaction

## Operation
- Reset values: in_ready=1, out_valid=0, a=0, c=0, busy=0, all stage valids 0, active mode = pipelined.
- Global advance: `adv = !out_valid || out_ready`; `in_ready = adv`. Accept when `in_valid && in_ready`.
- Pipelined mode: stage 0 captures `s0 = b + d`, `a0 = b + d`, `d0 = d`. Stage k (1..DEPTH-1) captures `sk = s(k-1) + d(k-1)`, carries a and d. The last stage drives a, c, and out_valid. Bubbles propagate; there is no bubble collapsing.
- Collapsed mode: one register captures `a = b + d` and `c = b + DEPTH*d`, computed as a chain of DEPTH combinational adds. The result is valid one cycle after accept.
- Active mode latch: `collapse` is sampled into the active mode only on a cycle where busy=0 and no transaction is being accepted. While busy, changes to `collapse` are ignored until the pipeline drains.
- Arithmetic: every add is WIDTH-bit, modulo 2^WIDTH (wrap), unless SAT is configured (see Configuration).
- Stall: with out_valid=1 and out_ready=0, all stages, a and c hold, and in_ready=0.
- Simultaneous accept and output take in the same cycle: legal, full throughput of 1 transaction/cycle.
- Reset mid-operation clears all valids immediately (asynchronous). In-flight transactions are lost and the mode returns to pipelined.

## Timing
- Pipelined: accept at edge N → out_valid at edge N+DEPTH-1 (visible DEPTH cycles after the accepting cycle), assuming no stall.
- Collapsed: accept at edge N → out_valid after edge N.
- a and c change only on a rising Clock edge where adv=1. They hold their last value when out_valid falls.
- busy is registered: 1 from the edge after the first accept until the edge after the last valid leaves.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid.

## Configuration
- `ASSIGN_CHAIN_SAT_EN` defined: every add saturates at 2^WIDTH-1. Once a stage saturates, all later stages of that transaction stay saturated.
- Not defined: plain wrap-around addition with carry-out discarded.

## Structure
- Package `assign_chain_pkg`:
  - `mode_t` enum (MODE_PIPE, MODE_COLLAPSE)
  - function `chain_add(x, y)` implementing wrap or saturate under the macro
  - WIDTH-independent constants
- Sub-module `assign_chain_stage`: one register stage holding the s, a and d registers plus valid, with the enable tied to adv. Instantiate it DEPTH times via generate.

## Test plan
- WIDTH=4, DEPTH=2, pipelined, b=2, d=2 single accept → after 2 cycles out_valid=1, a=4, c=6; busy high for 2 cycles.
- Same operands with collapse=1 while idle → out_valid one cycle after accept, a=4, c=6.
- b=15, d=3, DEPTH=2 → wrap build: a=2, c=5; SAT build: a=15, c=15.
- Back-to-back pairs (1,1), (2,1), (3,1) with out_ready held 0 for 3 cycles mid-stream → no loss or duplication. Outputs in order: (2,3), (3,4), (4,5); in_ready=0 during the stall.
- Toggle collapse to 1 while busy → results still at pipelined latency. The new mode applies only to the first accept after busy=0.
- Assert Reset while 2 transactions are in flight → out_valid=0, a=0, c=0, busy=0 immediately. Mode returns to pipelined, and the first accept after reset release produces correct results.

Source files
------------

// File: rtl/assign_chain_pkg.sv
// assign_chain_pkg -- shared types and arithmetic for the assign_chain datapath.
//   mode_t     : active evaluation mode (pipelined shift chain or collapsed).
//   CHAIN_MAXW : widest operand chain_add supports (WIDTH must not exceed it).
//   chain_add  : one chain add at a runtime-given width. It wraps modulo 2^w,
//                or saturates at 2^w-1 when ASSIGN_CHAIN_SAT_EN is defined.
package assign_chain_pkg;

  typedef enum logic {
    MODE_PIPE     = 1'b0,
    MODE_COLLAPSE = 1'b1
  } mode_t;

  localparam int unsigned CHAIN_MAXW = 32;

  function automatic logic [CHAIN_MAXW-1:0] chain_add(
    input logic [CHAIN_MAXW-1:0] x,
    input logic [CHAIN_MAXW-1:0] y,
    input int unsigned           w
  );
    logic [CHAIN_MAXW:0] sum;
    logic [CHAIN_MAXW:0] lim;
    lim = ((CHAIN_MAXW+1)'(1) << w) - (CHAIN_MAXW+1)'(1);
    sum = {1'b0, x} + {1'b0, y};
`ifdef ASSIGN_CHAIN_SAT_EN
    if (sum > lim) sum = lim;
`endif
    sum = sum & lim;
    return sum[CHAIN_MAXW-1:0];
  endfunction

endpackage

// File: rtl/assign_chain_stage.sv
// assign_chain_stage -- one register stage of the accumulate chain.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_en              : global advance; the stage loads only when it is high
//   i_valid           : incoming valid (a 0 loads a bubble)
//   i_s, i_a, i_d     : partial sum, first-stage sum, increment to capture
//   o_valid, o_s, o_a, o_d : registered copies
// The data registers load only with a valid transaction, so a bubble leaves
// the previous result visible on the outputs.
module assign_chain_stage
  import assign_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_s,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_d
);

  logic             r_valid;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_s     <= '0;
      r_a     <= '0;
      r_d     <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_s <= i_s;
        r_a <= i_a;
        r_d <= i_d;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_s     = r_s;
  assign o_a     = r_a;
  assign o_d     = r_d;

endmodule

// File: rtl/assign_chain.sv
// assign_chain -- accumulate-chain pipeline producing a = b + d and
// c = b + DEPTH*d per accepted operand pair, with valid/ready flow control.
//   WIDTH (<= CHAIN_MAXW), DEPTH (>= 2)
//   i_clk, i_rst               : clock, asynchronous active-high reset
//   i_in_valid / o_in_ready    : operand handshake (o_in_ready = advance)
//   i_b, i_d                   : base and increment operands
//   i_collapse                 : mode request, latched only while idle
//   o_out_valid / i_out_ready  : result handshake
//   o_a, o_c                   : b + d and b + DEPTH*d of presented result
//   o_busy                     : some stage holds a valid transaction
// Build option: ASSIGN_CHAIN_SAT_EN selects saturating adds instead of wrap.
module assign_chain
  import assign_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_collapse,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_c,
  output logic             o_busy
);

  function automatic logic [WIDTH-1:0] add_w(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [CHAIN_MAXW-1:0] t;
    t = chain_add(CHAIN_MAXW'(x), CHAIN_MAXW'(y), WIDTH);
    return t[WIDTH-1:0];
  endfunction

  mode_t            r_mode;
  logic             w_adv;
  logic             w_accept;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_s   [DEPTH];
  logic [WIDTH-1:0] w_a   [DEPTH];
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic [WIDTH-1:0] w_sin [DEPTH];
  logic [WIDTH-1:0] w_ain [DEPTH];
  logic [WIDTH-1:0] w_din [DEPTH];
  logic [WIDTH-1:0] w_sum1;
  logic [WIDTH-1:0] w_chain;
  logic             w_unused_d;

  assign w_adv       = !o_out_valid || i_out_ready;
  assign w_accept    = i_in_valid && w_adv;
  assign o_in_ready  = w_adv;
  assign o_out_valid = w_v[DEPTH-1];
  assign o_a         = w_a[DEPTH-1];
  assign o_c         = w_s[DEPTH-1];
  assign o_busy      = |w_v;
  assign w_unused_d  = ^w_d[DEPTH-1];

  // Collapsed evaluation: DEPTH combinational adds feeding the last stage.
  always_comb begin
    w_sum1  = add_w(i_b, i_d);
    w_chain = w_sum1;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      w_chain = add_w(w_chain, i_d);
    end
  end

  // Mode can only change while the chain is empty, so the pipelined and
  // collapsed paths never hold live transactions at the same time.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_PIPE;
    end else if (!o_busy && !w_accept) begin
      r_mode <= i_collapse ? MODE_COLLAPSE : MODE_PIPE;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_vin[k] = w_accept && (r_mode == MODE_PIPE);
      assign w_sin[k] = w_sum1;
      assign w_ain[k] = w_sum1;
      assign w_din[k] = i_d;
    end else if (k == DEPTH - 1) begin : g_last
      // The last stage doubles as the single collapsed-mode register.
      assign w_vin[k] = (r_mode == MODE_COLLAPSE) ? w_accept : w_v[k-1];
      assign w_sin[k] = (r_mode == MODE_COLLAPSE) ? w_chain : add_w(w_s[k-1], w_d[k-1]);
      assign w_ain[k] = (r_mode == MODE_COLLAPSE) ? w_sum1  : w_a[k-1];
      assign w_din[k] = (r_mode == MODE_COLLAPSE) ? i_d     : w_d[k-1];
    end else begin : g_mid
      assign w_vin[k] = w_v[k-1];
      assign w_sin[k] = add_w(w_s[k-1], w_d[k-1]);
      assign w_ain[k] = w_a[k-1];
      assign w_din[k] = w_d[k-1];
    end

    assign_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (w_adv),
      .i_valid (w_vin[k]),
      .i_s     (w_sin[k]),
      .i_a     (w_ain[k]),
      .i_d     (w_din[k]),
      .o_valid (w_v[k]),
      .o_s     (w_s[k]),
      .o_a     (w_a[k]),
      .o_d     (w_d[k])
    );
  end

endmodule

// File: tb/tb_assign_chain.sv
// tb_assign_chain -- directed bench for assign_chain at WIDTH=4, DEPTH=2.
module tb_assign_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] b;
  logic [3:0] d;
  logic       collapse;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] a;
  logic [3:0] c;
  logic       busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  assign_chain #(.WIDTH(4), .DEPTH(2)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_b         (b),
    .i_d         (d),
    .i_collapse  (collapse),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_a         (a),
    .o_c         (c),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] ea,
                         input logic [3:0] ec);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".a"}, 32'(a), 32'(ea));
    chk({tag, ".c"}, 32'(c), 32'(ec));
  endtask

  logic [3:0] sat_a;
  logic [3:0] sat_c;

  initial begin
`ifdef ASSIGN_CHAIN_SAT_EN
    sat_a = 4'd15; sat_c = 4'd15;
`else
    sat_a = 4'd2;  sat_c = 4'd5;
`endif
    rst = 1'b0; in_valid = 1'b0; b = '0; d = '0; collapse = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk_out("rst", 1'b0, 4'd0, 4'd0);
    tick(); tick();
    rst = 1'b0;

    // Pipelined single transaction: b=2, d=2
    in_valid = 1'b1; b = 4'd2; d = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("p1.busy1", 32'(busy), 32'd1);
    chk("p1.ov1", 32'(out_valid), 32'd0);
    tick();
    chk_out("p1.res", 1'b1, 4'd4, 4'd6);
    chk("p1.busy2", 32'(busy), 32'd1);
    tick();
    chk_out("p1.drain", 1'b0, 4'd4, 4'd6);
    chk("p1.busy3", 32'(busy), 32'd0);

    // Collapsed single transaction after an idle cycle to latch the mode
    collapse = 1'b1;
    tick();
    in_valid = 1'b1; b = 4'd2; d = 4'd2;
    tick();
    in_valid = 1'b0;
    chk_out("c1.res", 1'b1, 4'd4, 4'd6);
    tick();
    chk("c1.drain", 32'(out_valid), 32'd0);

    // Overflow boundary in collapsed mode
    in_valid = 1'b1; b = 4'd15; d = 4'd3;
    tick();
    in_valid = 1'b0;
    chk_out("c2.ovf", 1'b1, sat_a, sat_c);

    // Overflow boundary in pipelined mode
    collapse = 1'b0;
    tick(); tick();
    in_valid = 1'b1; b = 4'd15; d = 4'd3;
    tick();
    in_valid = 1'b0;
    chk("p2.ov1", 32'(out_valid), 32'd0);
    tick();
    chk_out("p2.ovf", 1'b1, sat_a, sat_c);
    tick();

    // Back-to-back with a 3-cycle stall
    in_valid = 1'b1; b = 4'd1; d = 4'd1;
    tick();
    b = 4'd2;
    tick();
    chk_out("bb.t1", 1'b1, 4'd2, 4'd3);
    out_ready = 1'b0; b = 4'd3;
    #1;
    chk("bb.in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bb.stall", 1'b1, 4'd2, 4'd3);
      chk("bb.stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bb.in_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bb.t2", 1'b1, 4'd3, 4'd4);
    tick();
    chk_out("bb.t3", 1'b1, 4'd4, 4'd5);
    tick();
    chk("bb.end_ov", 32'(out_valid), 32'd0);
    chk("bb.end_busy", 32'(busy), 32'd0);

    // Mode request changes while busy are ignored until drained
    in_valid = 1'b1; b = 4'd5; d = 4'd1;
    tick();
    in_valid = 1'b0; collapse = 1'b1;
    chk("mb.ov1", 32'(out_valid), 32'd0);
    tick();
    chk_out("mb.pipe", 1'b1, 4'd6, 4'd7);
    tick();
    chk("mb.busy0", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b1; b = 4'd5; d = 4'd1;
    tick();
    in_valid = 1'b0;
    chk_out("mb.coll", 1'b1, 4'd6, 4'd7);
    tick();

    // Reset with two transactions in flight
    collapse = 1'b0;
    tick();
    in_valid = 1'b1; b = 4'd1; d = 4'd2;
    tick();
    b = 4'd3; d = 4'd3;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; collapse = 1'b1;
    chk("rm.busy", 32'(busy), 32'd1);
    chk_out("rm.pre", 1'b1, 4'd3, 4'd5);
    #1 rst = 1'b1;
    #1;
    chk_out("rm.rst", 1'b0, 4'd0, 4'd0);
    chk("rm.busy0", 32'(busy), 32'd0);
    chk("rm.in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; b = 4'd4; d = 4'd1;
    tick();
    in_valid = 1'b0;
    chk("rm.ov1", 32'(out_valid), 32'd0);
    tick();
    chk_out("rm.after", 1'b1, 4'd5, 4'd6);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
